element_loader_ctrl: RTL and testbench
======================================

# element_loader_ctrl

Parametrised element-entry controller for the circuit-input stage. It walks the user through NUM_FIELDS fields per circuit element using the go button's press/release handshake, and allows stepping back one field with a back button. It assembles the fields into one packed record and writes that record to element memory at the current element count. It sits between the switch/button front end and element memory, and signals the downstream solver stage with end_process once entry is complete or memory is full.

## Interface
Parameters:
- NUM_FIELDS, 5, fields per element (0 type, 1 value, 2 exponent, 3 node A, 4 node B); must be ≥ 2
- FIELD_W, 8, bits per field
- MAX_ELEMENTS, 16, element memory depth; must be ≥ 2
- IDX_W, $clog2(NUM_FIELDS), derived
- ADDR_W, $clog2(MAX_ELEMENTS+1), derived

Ports:
- clk  in  1  system clock; one clock domain; all state changes on posedge clk
- program_reset  in  1  synchronous, active-high; full reset
- input_reset  in  1  synchronous, active-high; aborts the element being entered
- start_process  in  1  level; leaves IDLE
- input_over  in  1  level; user finished entering elements
- go  in  1  debounced advance button, active-high
- back  in  1  debounced step-back button, active-high
- field_in  in  FIELD_W  switch value for the current field
- field_idx  out  IDX_W  index of the field being entered
- do_display  out  1  high in DISPLAY
- record  out  NUM_FIELDS*FIELD_W  assembled record; field i occupies bits [i*FIELD_W +: FIELD_W]
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  equals element_count
- mem_wdata  out  NUM_FIELDS*FIELD_W  equals record
- element_count  out  ADDR_W  number of committed elements
- full  out  1  element_count == MAX_ELEMENTS
- end_process  out  1  high in DONE
- current_state  out  3  state code, for debug LEDs

## Operation
- States: IDLE, DISPLAY, DISPLAY_WAIT, FIELD_LOAD, FIELD_WAIT, BACK_WAIT, COMMIT, DONE.
- IDLE → DISPLAY when start_process = 1.
- DISPLAY:
  - input_over → DONE.
  - otherwise go → DISPLAY_WAIT.
- DISPLAY_WAIT: on !go → FIELD_LOAD with field_idx = 0.
- FIELD_LOAD:
  - go → FIELD_WAIT; record[field_idx] ← field_in on that edge.
  - back && !go && field_idx > 0 → BACK_WAIT; field_idx decrements on that edge.
  - back with field_idx == 0 is ignored.
  - go and back together: go wins.
- FIELD_WAIT: on !go:
  - field_idx < NUM_FIELDS−1 → FIELD_LOAD; field_idx increments.
  - otherwise → COMMIT.
- BACK_WAIT: on !back → FIELD_LOAD. The previously captured value stays in record until it is overwritten.
- COMMIT (one cycle):
  - mem_we = 1 and element_count increments on the exit edge.
  - Exits to DONE if the new count equals MAX_ELEMENTS, else to DISPLAY.
  - record is cleared to 0 on the exit edge.
- DONE: sticky. end_process = 1. Only program_reset leaves it.
- input_reset:
  - In FIELD_LOAD, FIELD_WAIT, BACK_WAIT, DISPLAY or DISPLAY_WAIT: → DISPLAY, record ← 0, field_idx ← 0; element_count unchanged.
  - Ignored in IDLE, COMMIT and DONE.
- Precedence: program_reset > input_reset > normal transition.
- Reset values: state IDLE; field_idx, record, element_count 0; mem_we, do_display, end_process, full 0.

## Timing
- All outputs are registered or decoded from registered state (Moore); no input reaches an output combinationally.
- Field capture happens on the edge where go is first sampled high in FIELD_LOAD; field_in is don't-care afterwards.
- mem_we rises one cycle after the edge that samples go low in FIELD_WAIT of the last field, and lasts exactly one cycle.
- During that cycle mem_addr = pre-increment count and mem_wdata = the complete record.
- full and end_process rise on the same edge that leaves COMMIT with count = MAX_ELEMENTS.
- Minimum element entry: 2 + 2·NUM_FIELDS + 1 button-phase cycles; each button phase lasts ≥ 1 cycle.

## Structure
- Package element_pkg holds:
  - the state encoding localparams;
  - field index constants FLD_TYPE, FLD_VALUE, FLD_EXP, FLD_NODE_A, FLD_NODE_B;
  - default FIELD_W and MAX_ELEMENTS.
- One sub-module, element_record_reg, owns the record register bank:
  - inputs: clk, clear, wr_en, wr_idx, wr_data;
  - output: the packed record.
- The FSM, field index counter and element counter stay in the top module.

## Test plan
All scenarios use NUM_FIELDS=5, FIELD_W=8, MAX_ELEMENTS=4.
- Basic entry: start, then enter fields 0x01, 0x22, 0x03, 0x04, 0x05 → single mem_we with mem_addr=0, mem_wdata=0x0504032201; element_count=1; state returns to DISPLAY.
- Back edit: enter 0x11 and 0x22, press back, re-enter 0x33 for field 1, finish with 0x44, 0x55, 0x66 → mem_wdata=0x6655443311.
- Back at field 0: back pulse with field_idx=0 → state and field_idx unchanged. go and back together in FIELD_LOAD → FIELD_WAIT, no decrement.
- input_reset during field 3 of element 2 → DISPLAY, record=0, element_count stays 1, no mem_we; the next full entry writes to addr 1.
- Capacity: commit 4 elements → full=1 and end_process=1 on the same edge after the 4th mem_we; further go/input_reset have no effect until program_reset.
- input_over in DISPLAY after 2 elements → DONE, element_count=2. program_reset mid-FIELD_WAIT → IDLE with all outputs 0 on the next cycle.

Source files
------------

// File: rtl/element_pkg.sv
// element_pkg: shared state codes, field indices and default sizes for the element loader.
package element_pkg;
    localparam int NUM_FIELDS_DEF   = 5;
    localparam int FIELD_W_DEF      = 8;
    localparam int MAX_ELEMENTS_DEF = 16;

    localparam int FLD_TYPE   = 0;
    localparam int FLD_VALUE  = 1;
    localparam int FLD_EXP    = 2;
    localparam int FLD_NODE_A = 3;
    localparam int FLD_NODE_B = 4;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_DISPLAY      = 3'd1;
    localparam logic [2:0] ST_DISPLAY_WAIT = 3'd2;
    localparam logic [2:0] ST_FIELD_LOAD   = 3'd3;
    localparam logic [2:0] ST_FIELD_WAIT   = 3'd4;
    localparam logic [2:0] ST_BACK_WAIT    = 3'd5;
    localparam logic [2:0] ST_COMMIT       = 3'd6;
    localparam logic [2:0] ST_DONE         = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE         = ST_IDLE,
        S_DISPLAY      = ST_DISPLAY,
        S_DISPLAY_WAIT = ST_DISPLAY_WAIT,
        S_FIELD_LOAD   = ST_FIELD_LOAD,
        S_FIELD_WAIT   = ST_FIELD_WAIT,
        S_BACK_WAIT    = ST_BACK_WAIT,
        S_COMMIT       = ST_COMMIT,
        S_DONE         = ST_DONE
    } state_t;
endpackage

// File: rtl/element_record_reg.sv
// element_record_reg: packed record register bank, one field written per cycle.
// Ports: clk; clear (zeroes whole record, wins over write); wr_en/wr_idx/wr_data
// (field write); record (packed, field i at [i*FIELD_W +: FIELD_W]).
module element_record_reg #(
    parameter int NUM_FIELDS = 5,
    parameter int FIELD_W    = 8,
    parameter int IDX_W      = $clog2(NUM_FIELDS)
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [FIELD_W-1:0]            wr_data,
    output logic [NUM_FIELDS*FIELD_W-1:0] record
);
    always_ff @(posedge clk) begin
        if (clear)
            record <= '0;
        else
            for (int i = 0; i < NUM_FIELDS; i++)
                if (wr_en && wr_idx == IDX_W'(i))
                    record[i*FIELD_W +: FIELD_W] <= wr_data;
    end
endmodule

// File: rtl/element_loader_ctrl.sv
// element_loader_ctrl: go/back driven per-field entry of circuit elements into element memory.
// Ports: clk; program_reset (full reset), input_reset (abort current element);
// start_process, input_over, go, back, field_in (front end);
// field_idx, do_display, record, current_state (user feedback);
// mem_we, mem_addr, mem_wdata (element memory); element_count, full, end_process (solver).
module element_loader_ctrl
    import element_pkg::*;
#(
    parameter int NUM_FIELDS   = NUM_FIELDS_DEF,
    parameter int FIELD_W      = FIELD_W_DEF,
    parameter int MAX_ELEMENTS = MAX_ELEMENTS_DEF,
    parameter int IDX_W        = $clog2(NUM_FIELDS),
    parameter int ADDR_W       = $clog2(MAX_ELEMENTS + 1)
) (
    input  logic                          clk,
    input  logic                          program_reset,
    input  logic                          input_reset,
    input  logic                          start_process,
    input  logic                          input_over,
    input  logic                          go,
    input  logic                          back,
    input  logic [FIELD_W-1:0]            field_in,
    output logic [IDX_W-1:0]              field_idx,
    output logic                          do_display,
    output logic [NUM_FIELDS*FIELD_W-1:0] record,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [NUM_FIELDS*FIELD_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0]             element_count,
    output logic                          full,
    output logic                          end_process,
    output logic [2:0]                    current_state
);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_FIELDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ELEMENTS - 1);
    localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(MAX_ELEMENTS);

    state_t state;
    logic   abortable;
    logic   rec_clear;
    logic   rec_we;

    // input_reset only aborts states where a partial element may be in flight
    assign abortable = state inside {S_DISPLAY, S_DISPLAY_WAIT, S_FIELD_LOAD, S_FIELD_WAIT, S_BACK_WAIT};
    assign rec_clear = program_reset || (input_reset && abortable) || state == S_COMMIT;
    assign rec_we    = state == S_FIELD_LOAD && go;

    element_record_reg #(
        .NUM_FIELDS(NUM_FIELDS),
        .FIELD_W   (FIELD_W),
        .IDX_W     (IDX_W)
    ) u_rec (
        .clk    (clk),
        .clear  (rec_clear),
        .wr_en  (rec_we),
        .wr_idx (field_idx),
        .wr_data(field_in),
        .record (record)
    );

    always_ff @(posedge clk) begin
        if (program_reset) begin
            state         <= S_IDLE;
            field_idx     <= '0;
            element_count <= '0;
        end else if (input_reset && abortable) begin
            state     <= S_DISPLAY;
            field_idx <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (start_process) state <= S_DISPLAY;
                S_DISPLAY:
                    if (input_over) state <= S_DONE;
                    else if (go) state <= S_DISPLAY_WAIT;
                S_DISPLAY_WAIT:
                    if (!go) begin
                        state     <= S_FIELD_LOAD;
                        field_idx <= '0;
                    end
                S_FIELD_LOAD:
                    if (go) begin
                        state <= S_FIELD_WAIT;
                    end else if (back && field_idx != '0) begin
                        state     <= S_BACK_WAIT;
                        field_idx <= field_idx - 1'b1;
                    end
                S_FIELD_WAIT:
                    if (!go) begin
                        if (field_idx != LAST_IDX) begin
                            state     <= S_FIELD_LOAD;
                            field_idx <= field_idx + 1'b1;
                        end else begin
                            state <= S_COMMIT;
                        end
                    end
                S_BACK_WAIT:
                    if (!back) state <= S_FIELD_LOAD;
                S_COMMIT: begin
                    element_count <= element_count + 1'b1;
                    field_idx     <= '0;
                    state         <= element_count == LAST_ADDR ? S_DONE : S_DISPLAY;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from registered state and counters
    assign do_display    = state == S_DISPLAY;
    assign mem_we        = state == S_COMMIT;
    assign end_process   = state == S_DONE;
    assign mem_addr      = element_count;
    assign mem_wdata     = record;
    assign full          = element_count == MAX_ADDR;
    assign current_state = state;
endmodule

// File: tb/tb_element_loader_ctrl.sv
// tb_element_loader_ctrl: directed and randomized checks of element_loader_ctrl against a field-level model.
module tb_element_loader_ctrl;
    import element_pkg::*;

    localparam int NF = 5;
    localparam int FW = 8;
    localparam int ME = 4;
    localparam int IW = $clog2(NF);
    localparam int AW = $clog2(ME + 1);

    logic clk = 0;
    logic program_reset = 1, input_reset = 0, start_process = 0, input_over = 0, go = 0, back = 0;
    logic [FW-1:0]    field_in = '0;
    logic [IW-1:0]    field_idx;
    logic             do_display, mem_we, full, end_process;
    logic [NF*FW-1:0] record, mem_wdata;
    logic [AW-1:0]    mem_addr, element_count;
    logic [2:0]       current_state;

    element_loader_ctrl #(.NUM_FIELDS(NF), .FIELD_W(FW), .MAX_ELEMENTS(ME)) dut (
        .clk(clk), .program_reset(program_reset), .input_reset(input_reset),
        .start_process(start_process), .input_over(input_over), .go(go), .back(back),
        .field_in(field_in), .field_idx(field_idx), .do_display(do_display), .record(record),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .element_count(element_count), .full(full), .end_process(end_process),
        .current_state(current_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int we_seen = 0;
    int model_count = 0;
    logic [FW-1:0] fld [NF];

    always @(negedge clk) if (mem_we) we_seen++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NF*FW-1:0] pack_fields();
        logic [NF*FW-1:0] r = '0;
        for (int i = 0; i < NF; i++) r = r | ({{(NF-1)*FW{1'b0}}, fld[i]} << (FW * i));
        return r;
    endfunction

    task automatic press(input logic [FW-1:0] v);
        field_in = v; go = 1; cyc(1);
        field_in = FW'($urandom); go = 0; cyc(1);
    endtask

    task automatic do_reset();
        program_reset = 1; cyc(1); program_reset = 0;
        model_count = 0;
    endtask

    // Enter one element from DISPLAY using fld[]; when bk is set, one field gets junk first,
    // then is backed over and re-entered.
    task automatic enter_element(input string tag, input bit bk);
        int k = bk ? int'($urandom_range(1, NF - 1)) : NF + 1;
        int seen0 = we_seen;
        go = 1; cyc(1); go = 0; cyc(1);
        for (int i = 0; i < NF; i++) begin
            if (i == k - 1) begin
                press(~fld[i]);
                back = 1; cyc(1);
                check({tag, ".back_idx"}, 64'(field_idx), 64'(i));
                back = 0; cyc(1);
            end
            press(fld[i]);
        end
        check({tag, ".we"}, 64'(mem_we), 64'd1);
        check({tag, ".addr"}, 64'(mem_addr), 64'(model_count));
        check({tag, ".wdata"}, 64'(mem_wdata), 64'(pack_fields()));
        cyc(1);
        model_count++;
        check({tag, ".we_once"}, 64'(we_seen - seen0), 64'd1);
        check({tag, ".count"}, 64'(element_count), 64'(model_count));
        check({tag, ".rec_clr"}, 64'(record), 64'd0);
        check({tag, ".state"}, 64'(current_state), 64'(model_count == ME ? ST_DONE : ST_DISPLAY));
        check({tag, ".full"}, 64'(full), 64'(model_count == ME));
        check({tag, ".endp"}, 64'(end_process), 64'(model_count == ME));
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NF; i++) fld[i] = FW'($urandom);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".state"}, 64'(current_state), 64'(ST_IDLE));
        check({tag, ".idx"}, 64'(field_idx), 64'd0);
        check({tag, ".rec"}, 64'(record), 64'd0);
        check({tag, ".misc"}, {58'd0, mem_we, do_display, end_process, full, 2'd0}, 64'd0);
        check({tag, ".count"}, 64'(element_count), 64'd0);
    endtask

    initial begin
        int seen;
        cyc(2);
        program_reset = 0;
        check_zero("reset");

        start_process = 1; cyc(1); start_process = 0;
        check("start.state", 64'(current_state), 64'(ST_DISPLAY));
        check("start.disp", 64'(do_display), 64'd1);

        fld = '{8'h01, 8'h22, 8'h03, 8'h04, 8'h05};
        check("basic.model", 64'(pack_fields()), 64'h0504032201);
        enter_element("basic", 0);

        // back edit: field 1 entered as 0x22, stepped back over, re-entered as 0x33
        go = 1; cyc(1); go = 0; cyc(1);
        press(8'h11); press(8'h22);
        back = 1; cyc(1);
        check("bk.state", 64'(current_state), 64'(ST_BACK_WAIT));
        check("bk.idx", 64'(field_idx), 64'd1);
        back = 0; cyc(1);
        check("bk.keep", 64'(record[15:8]), 64'h22);
        press(8'h33); press(8'h44); press(8'h55); press(8'h66);
        check("bk.wdata", 64'(mem_wdata), 64'h6655443311);
        check("bk.addr", 64'(mem_addr), 64'd1);
        cyc(1); model_count++;
        check("bk.count", 64'(element_count), 64'd2);

        // back at field 0 ignored; go+back together: go wins
        go = 1; cyc(1); go = 0; cyc(1);
        back = 1; cyc(1);
        check("b0.state", 64'(current_state), 64'(ST_FIELD_LOAD));
        check("b0.idx", 64'(field_idx), 64'd0);
        field_in = 8'hAA; go = 1; cyc(1);
        check("gb.state", 64'(current_state), 64'(ST_FIELD_WAIT));
        check("gb.idx", 64'(field_idx), 64'd0);
        check("gb.rec", 64'(record[7:0]), 64'hAA);
        go = 0; back = 0; cyc(1);
        press(8'h01); press(8'h02);
        check("ir.idx3", 64'(field_idx), 64'd3);
        seen = we_seen;
        field_in = 8'h09; go = 1; cyc(1);
        input_reset = 1; cyc(1); input_reset = 0; go = 0;
        check("ir.state", 64'(current_state), 64'(ST_DISPLAY));
        check("ir.rec", 64'(record), 64'd0);
        check("ir.idx", 64'(field_idx), 64'd0);
        check("ir.count", 64'(element_count), 64'd2);
        check("ir.nowe", 64'(we_seen - seen), 64'd0);

        rand_fields(); enter_element("r3", 1);
        rand_fields(); enter_element("cap", 0);

        // DONE is sticky against everything but program_reset
        seen = we_seen;
        go = 1; input_reset = 1; start_process = 1; input_over = 1; cyc(2);
        go = 0; input_reset = 0; start_process = 0; input_over = 0; cyc(2);
        check("sticky.state", 64'(current_state), 64'(ST_DONE));
        check("sticky.count", 64'(element_count), 64'(ME));
        check("sticky.nowe", 64'(we_seen - seen), 64'd0);
        check("sticky.full", 64'(full), 64'd1);

        do_reset();
        check_zero("prst1");
        start_process = 1; cyc(1); start_process = 0;
        rand_fields(); enter_element("io1", 1);
        rand_fields(); enter_element("io2", 0);
        input_over = 1; cyc(1); input_over = 0;
        check("io.state", 64'(current_state), 64'(ST_DONE));
        check("io.count", 64'(element_count), 64'd2);
        check("io.endp", 64'(end_process), 64'd1);
        check("io.full", 64'(full), 64'd0);

        do_reset();
        start_process = 1; cyc(1); start_process = 0;
        go = 1; cyc(1); go = 0; cyc(1);
        field_in = 8'h5A; go = 1; cyc(1);
        check("pr.fw", 64'(current_state), 64'(ST_FIELD_WAIT));
        program_reset = 1; cyc(1); program_reset = 0; go = 0;
        check_zero("prst2");

        start_process = 1; cyc(1); start_process = 0;
        for (int n = 0; n < ME; n++) begin
            rand_fields();
            enter_element("rnd", 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
